leaky_integrator_mc: RTL and testbench

LEAKY_INTEGRATOR_MC -- requirements
Module: leaky_integrator_mc

---
 rtl/leaky_integrator_mc.sv | 91 +++++++++
 tb/tb_leaky_integrator_mc.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/leaky_integrator_mc.sv
// leaky_integrator_mc: multi-channel two-stage leaky integrator, S[n]=x+Alpha*S[n-1], OutSmooth=AlphaCap*S[n]
// Ports: Clk, RESET (async, active-low); LIdvi/LIch/LIclr/InLeaky/Alpha/AlphaCap accept one sample per cycle;
//        LIdvo/OutCh/OutSmooth present the result two cycles later; OvfFlag is a sticky overflow flag.
// Macro LEAKY_INTEGRATOR_SAT_EN: saturate out-of-range sums/products instead of wrapping them.
module leaky_integrator_mc #(
    parameter int WI = 12,
    parameter int WF = 12,
    parameter int NCH = 4,
    localparam int W = WI + WF,
    localparam int CW = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                Clk,
    input  logic                RESET,
    input  logic                LIdvi,
    input  logic [CW-1:0]       LIch,
    input  logic                LIclr,
    input  logic signed [W-1:0] InLeaky,
    input  logic signed [W-1:0] Alpha,
    input  logic signed [W-1:0] AlphaCap,
    output logic                LIdvo,
    output logic [CW-1:0]       OutCh,
    output logic signed [W-1:0] OutSmooth,
    output logic                OvfFlag
);
`ifdef LEAKY_INTEGRATOR_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif
    localparam logic signed [W-1:0] MAX_V = {1'b0, {(W-1){1'b1}}};
    localparam logic signed [W-1:0] MIN_V = {1'b1, {(W-1){1'b0}}};
    localparam logic [CW:0] NCH_V = (CW+1)'(NCH);

    logic signed [W-1:0] st [2**CW];
    logic                v1;
    logic [CW-1:0]       ch1;
    logic signed [W-1:0] x1, ac1, p1;
    logic                acc, p_ovf, s_ovf, o_ovf;
    logic signed [W-1:0] s_prev, p_fit, s2, o_fit;
    logic signed [W:0]   sum;
    logic signed [2*W-1:0] pp, ps, op, os;

    always_comb begin
        acc = LIdvi && ({1'b0, LIch} < NCH_V);
        // stage 2: accumulate and scale
        sum = {x1[W-1], x1} + {p1[W-1], p1};
        s_ovf = sum[W] ^ sum[W-1];
        s2 = (SAT && s_ovf) ? (sum[W] ? MIN_V : MAX_V) : sum[W-1:0];
        op = ac1 * s2;
        os = op >>> WF;
        // realigned product fits only if everything above its sign bit is sign extension
        o_ovf = !(&os[2*W-1:W-1] || ~|os[2*W-1:W-1]);
        o_fit = (SAT && o_ovf) ? (os[2*W-1] ? MIN_V : MAX_V) : os[W-1:0];
        // stage 1: the sum being written this cycle is newer than storage for the same channel
        s_prev = LIclr ? '0 : (v1 && ch1 == LIch) ? s2 : st[LIch];
        pp = Alpha * s_prev;
        ps = pp >>> WF;
        p_ovf = !(&ps[2*W-1:W-1] || ~|ps[2*W-1:W-1]);
        p_fit = (SAT && p_ovf) ? (ps[2*W-1] ? MIN_V : MAX_V) : ps[W-1:0];
    end

    always_ff @(posedge Clk or negedge RESET) begin
        if (!RESET) begin
            for (int i = 0; i < 2**CW; i++) st[i] <= '0;
            v1 <= 1'b0;
            ch1 <= '0;
            x1 <= '0;
            ac1 <= '0;
            p1 <= '0;
            LIdvo <= 1'b0;
            OutCh <= '0;
            OutSmooth <= '0;
            OvfFlag <= 1'b0;
        end else begin
            v1 <= acc;
            LIdvo <= v1;
            OvfFlag <= OvfFlag | (acc & p_ovf) | (v1 & (s_ovf | o_ovf));
            if (acc) begin
                x1 <= InLeaky;
                ch1 <= LIch;
                ac1 <= AlphaCap;
                p1 <= p_fit;
            end
            if (v1) begin
                st[ch1] <= s2;
                OutCh <= ch1;
                OutSmooth <= o_fit;
            end
        end
    end
endmodule

// File: tb/tb_leaky_integrator_mc.sv
// tb_leaky_integrator_mc: table vectors, corner sequences and random stimulus against an arithmetic model
module tb_leaky_integrator_mc;
    localparam int WI = 12, WF = 12, NCH = 4, W = WI + WF, CW = 2;
    localparam longint MAXV = (longint'(1) << (W - 1)) - 1;
    localparam longint MINV = -(longint'(1) << (W - 1));
    localparam longint MASK = (longint'(1) << W) - 1;

    logic Clk = 1'b0, RESET = 1'b1, LIdvi = 1'b0, LIclr = 1'b0;
    logic [CW-1:0] LIch = '0;
    logic signed [W-1:0] InLeaky = '0, Alpha = '0, AlphaCap = '0;
    logic LIdvo, OvfFlag;
    logic [CW-1:0] OutCh;
    logic signed [W-1:0] OutSmooth;

    leaky_integrator_mc #(.WI(WI), .WF(WF), .NCH(NCH)) dut (
        .Clk(Clk), .RESET(RESET), .LIdvi(LIdvi), .LIch(LIch), .LIclr(LIclr),
        .InLeaky(InLeaky), .Alpha(Alpha), .AlphaCap(AlphaCap),
        .LIdvo(LIdvo), .OutCh(OutCh), .OutSmooth(OutSmooth), .OvfFlag(OvfFlag)
    );

    always #5 Clk = ~Clk;

    typedef struct { int due; int ch; longint out; } exp_t;
    typedef struct { int ch; int x; int al; int ac; bit clr; int out; } vec_t;
    exp_t q[$];
    vec_t tab[10];
    longint st_m[NCH];
    bit ovf_m = 1'b0;
    int cyc = 0, n_cmp = 0, n_bad = 0;

    always @(posedge Clk) cyc <= cyc + 1;

    function automatic void chk(string name, longint act, longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic longint fit(longint v);
        longint m = v & MASK;
        if (v > MAXV || v < MINV) ovf_m = 1'b1;
`ifdef LEAKY_INTEGRATOR_SAT_EN
        if (v > MAXV) return MAXV;
        if (v < MINV) return MINV;
`endif
        return (m > MAXV) ? m - (MASK + 1) : m;
    endfunction

    function automatic longint mul(longint a, longint b);
        return (a * b) >>> WF;
    endfunction

    function automatic longint model(int ch, int x, int al, int ac, bit clr);
        longint s = fit(longint'(x) + fit(mul(al, clr ? 0 : st_m[ch])));
        st_m[ch] = s;
        return fit(mul(ac, s));
    endfunction

    task automatic drive(input bit dv, input int ch, input int x, input int al, input int ac,
                         input bit clr, input bit use_exp = 1'b0, input longint exp_out = 0);
        longint o;
        @(posedge Clk);
        #1;
        LIdvi = dv; LIch = CW'(ch); LIclr = clr;
        InLeaky = W'(x); Alpha = W'(al); AlphaCap = W'(ac);
        if (dv && ch < NCH) begin
            o = model(ch, x, al, ac, clr);
            q.push_back('{cyc + 2, ch, use_exp ? exp_out : o});
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 0, 0, 0, 0, 1'b0);
    endtask

    always @(negedge Clk) begin
        if (RESET) begin
            if (q.size() > 0 && q[0].due == cyc) begin
                chk("dvo", LIdvo, 1);
                chk("out", OutSmooth, q[0].out);
                chk("outch", OutCh, q[0].ch);
                void'(q.pop_front());
            end else begin
                chk("dvo_idle", LIdvo, 0);
            end
        end
    end

    initial begin
        int xs[6];
        int fa, fc;
        tab[0] = '{0, 4096, 3686, 410, 1'b1, 410};
        tab[1] = '{0, 4096, 3686, 410, 1'b0, 778};
        tab[2] = '{0, 4096, 3686, 410, 1'b0, 1110};
        tab[3] = '{0, 4096, 3686, 410, 1'b0, 1409};
        tab[4] = '{0, 4096, 3686, 410, 1'b1, 410};
        tab[5] = '{1, -4096, 3686, 410, 1'b1, -410};
        tab[6] = '{0, 4096, 3686, 410, 1'b0, 778};
        tab[7] = '{1, -4096, 3686, 410, 1'b0, -779};
        tab[8] = '{0, 4096, 3686, 410, 1'b0, 1110};
        tab[9] = '{1, -4096, 3686, 410, 1'b0, -1112};
        for (int i = 0; i < NCH; i++) st_m[i] = 0;
        #1 RESET = 1'b0;
        #22;
        chk("rst_dvo", LIdvo, 0);
        chk("rst_out", OutSmooth, 0);
        chk("rst_ch", OutCh, 0);
        chk("rst_ovf", OvfFlag, 0);
        @(posedge Clk);
        #1 RESET = 1'b1;

        for (int i = 0; i < 10; i++)
            drive(1'b1, tab[i].ch, tab[i].x, tab[i].al, tab[i].ac, tab[i].clr, 1'b1, tab[i].out);
        idle(3);

        for (int i = 0; i < 4; i++) drive(1'b1, 0, 4096, 3686, 410, 1'b0);
        drive(1'b1, 0, 4096, 3686, 410, 1'b1, 1'b1, 410);
        idle(3);

        fa = int'($urandom_range(8191)) - 4096;
        fc = int'($urandom_range(8191)) - 4096;
        for (int i = 0; i < 6; i++) xs[i] = int'($urandom_range(65535)) - 32768;
        for (int i = 0; i < 6; i++) drive(1'b1, 2, xs[i], fa, fc, i == 0);
        idle(3);
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 2, xs[i], fa, fc, i == 0);
            idle(i % 3 + 1);
        end
        idle(3);
        chk("ovf_clear", OvfFlag, longint'(ovf_m));

        for (int i = 0; i < 4; i++) drive(1'b1, 3, int'(MAXV), 3686, 4096, i == 0);
        idle(3);
        chk("ovf_set", OvfFlag, 1);

        for (int i = 0; i < 3; i++) drive(1'b1, 0, 4096, 3686, 410, 1'b0);
        @(posedge Clk);
        #2 RESET = 1'b0;
        LIdvi = 1'b0;
        q.delete();
        for (int i = 0; i < NCH; i++) st_m[i] = 0;
        ovf_m = 1'b0;
        #1;
        chk("mid_rst_dvo", LIdvo, 0);
        chk("mid_rst_out", OutSmooth, 0);
        chk("mid_rst_ch", OutCh, 0);
        chk("mid_rst_ovf", OvfFlag, 0);
        repeat (2) @(posedge Clk);
        #1 RESET = 1'b1;
        drive(1'b1, 0, 4096, 3686, 410, 1'b0, 1'b1, 410);
        idle(3);

        for (int i = 0; i < 400; i++)
            drive($urandom_range(3) != 0, int'($urandom_range(NCH - 1)),
                  int'($urandom_range(65535)) - 32768, int'($urandom_range(8192)) - 4096,
                  int'($urandom_range(8192)) - 4096, $urandom_range(9) == 0);
        idle(4);
        chk("ovf_final", OvfFlag, longint'(ovf_m));
        chk("queue_drained", q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
